spi_bus_arbiter: RTL

//   Shares the single SPI master (START/BUSY handshake) among N_REQ on-board requesters
//   (sensor pollers, telemetry logger, config writer). Fair round-robin arbitration; one

---
 rtl/spi_bus_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// One START per grant, per-requester DONE, watchdog abort on a hung master.
module spi_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int CMD_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   CLK_26,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*CMD_W-1:0] CMD_IN,
  input  logic                   BUSY,
  output logic                   START,
  output logic [CMD_W-1:0]       CMD_OUT,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DONE,
  output logic                   TIMEOUT_ERR,
  output logic                   ACTIVE
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_XFER,
    S_FIN
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [TW-1:0]     timer_q;
  logic              start_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              to_q;
  logic              active_q;

  logic              win_vld_d;
  logic [PW-1:0]     win_d;
  logic [PW-1:0]     idx;
  logic              t_exp;

  assign t_exp = (timer_q == T_LAST);

  // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    idx       = '0;
    for (int o = 1; o <= N_REQ; o++) begin
      idx = PW'((int'(ptr_q) + o) % N_REQ);
      if (!win_vld_d && REQ[idx]) begin
        win_vld_d = 1'b1;
        win_d     = idx;
      end
    end
  end

  always_ff @(posedge CLK_26 or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(N_REQ - 1);
      timer_q  <= '0;
      start_q  <= 1'b0;
      cmd_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      to_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      to_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            gnt_q    <= N_REQ'(1) << win_d;
            cmd_q    <= CMD_IN[win_d*CMD_W +: CMD_W];
            ptr_q    <= win_d;
            active_q <= 1'b1;
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          start_q <= 1'b1;
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT, S_XFER: begin
          if (t_exp) begin
            to_q     <= 1'b1;
            gnt_q    <= '0;
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            if (timer_q != '1) timer_q <= timer_q + 1'b1;
            if (state_q == S_WAIT && BUSY) begin
              state_q <= S_XFER;
            end else if (state_q == S_XFER && !BUSY) begin
              done_q  <= gnt_q;
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          gnt_q    <= '0;
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign START       = start_q;
  assign CMD_OUT     = cmd_q;
  assign GNT         = gnt_q;
  assign DONE        = done_q;
  assign TIMEOUT_ERR = to_q;
  assign ACTIVE      = active_q;

endmodule
